// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//  mc_state_t   : multi-cycle sequencer states (ST_RUN / ST_MC_BUSY)
//  PC_SEL_SEQ/BR: pc_sel encodings (pc+4 / branch target)
//  load_use_hit : load-use detector for the instruction in ID against the load in EX
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } mc_state_t;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_BR  = 1'b1;
    localparam int   REG_W      = 5;

    // x0 is hard-wired to zero, so a load targeting it can never be a hazard.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic             use_rs1,
        input logic [REG_W-1:0] rs2,
        input logic             use_rs2
    );
        return mem_read && (rd != '0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bus between the core datapath and the hazard controller.
//  master : core side, drives hazard sources and perf_clr, receives controls
//  slave  : controller side, receives hazard sources, drives enables/flushes/
//           pc_sel, status flags and the two 32-bit performance counters
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_mc_start;
    logic             ex_mc_is_div;
    logic             branch_taken_ex;
    logic             mem_busy;
    logic             perf_clr;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             pc_sel;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             load_stall_out;
    logic             mc_busy;
    logic             mc_done;
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_mc_start, ex_mc_is_div, branch_taken_ex, mem_busy, perf_clr,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel, if_id_flush,
               id_ex_flush, ex_mem_flush, load_stall_out, mc_busy, mc_done,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_mc_start, ex_mc_is_div, branch_taken_ex, mem_busy, perf_clr,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel, if_id_flush,
               id_ex_flush, ex_mem_flush, load_stall_out, mc_busy, mc_done,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_mc_timer.sv
// Multi-cycle EX op timer: latency select, down-counter and done detection.
//  clk, rst  : clock, synchronous active-low reset
//  start     : op accepted this cycle (loads LAT-1)
//  busy      : sequencer is in ST_MC_BUSY
//  hold      : data memory wait, counter holds
//  is_div    : select DIV_LAT instead of MUL_LAT
//  cnt_zero  : counter has reached zero
//  done      : op leaves EX this cycle
module pipeline_hazard_ctrl_mc_timer #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic hold,
    input  logic is_div,
    output logic cnt_zero,
    output logic done
);
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] lat_m1;

    // The start cycle is itself a stall cycle, hence LAT-1.
    assign lat_m1 = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    always_comb begin
        cnt_next = cnt_reg;
        if (start) begin
            cnt_next = lat_m1;
        end else if (busy && !hold && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_zero = (cnt_reg == '0);
    assign done     = busy && !hold && cnt_zero;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline.
//  clk, rst : clock, synchronous active-low reset
//  hz       : hazard bus (slave side): hazard sources in; stage enables,
//             flushes, pc_sel, load_stall_out, mc_busy/mc_done and the
//             stall_cycles / flush_events counters out
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);
    mc_state_t state_reg;
    mc_state_t state_next;

    logic mc_start;
    logic mc_cnt_zero;
    logic mc_timer_done;
    logic mc_stall;
    logic load_use;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel;
    logic if_id_flush, id_ex_flush, ex_mem_flush, load_stall;
    logic redirect;

    // A memory wait freezes the sequencer, so an op is only accepted without it.
    assign mc_start = (state_reg == ST_RUN) && hz.ex_mc_start && !hz.mem_busy;

    pipeline_hazard_ctrl_mc_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (mc_start),
        .busy     (state_reg == ST_MC_BUSY),
        .hold     (hz.mem_busy),
        .is_div   (hz.ex_mc_is_div),
        .cnt_zero (mc_cnt_zero),
        .done     (mc_timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:     if (mc_start)      state_next = ST_MC_BUSY;
            ST_MC_BUSY: if (mc_timer_done) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    assign mc_stall = ((state_reg == ST_RUN) && hz.ex_mc_start) ||
                      ((state_reg == ST_MC_BUSY) && !mc_cnt_zero);
    assign load_use = load_use_hit(hz.ex_mem_read, hz.ex_rd, hz.id_rs1,
                                   hz.id_use_rs1, hz.id_rs2, hz.id_use_rs2);

    // Priority mux. A branch held under mem_busy stays in EX and is taken
    // in the first cycle the wait clears, which falls out of this ordering.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        pc_sel       = PC_SEL_SEQ;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        load_stall   = 1'b0;
        redirect     = 1'b0;
        if (!rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en}  = 4'b0000;
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
        end else if (hz.mem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en}  = 4'b0000;
        end else if (mc_stall) begin
            {pc_en, if_id_en, id_ex_en} = 3'b000;
            ex_mem_flush = 1'b1;
        end else if (hz.branch_taken_ex) begin
            pc_sel      = PC_SEL_BR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            load_stall  = 1'b1;
        end
    end

    // Performance counters: [0] stall cycles, [1] taken-branch redirects.
    logic [1:0]       perf_inc;
    logic [1:0][31:0] perf_val;

    assign perf_inc[0] = rst && !pc_en;
    assign perf_inc[1] = redirect;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!rst || hz.perf_clr) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign perf_val[gi] = cnt_reg;
        end
    endgenerate

    assign hz.pc_en          = pc_en;
    assign hz.if_id_en       = if_id_en;
    assign hz.id_ex_en       = id_ex_en;
    assign hz.ex_mem_en      = ex_mem_en;
    assign hz.pc_sel         = pc_sel;
    assign hz.if_id_flush    = if_id_flush;
    assign hz.id_ex_flush    = id_ex_flush;
    assign hz.ex_mem_flush   = ex_mem_flush;
    assign hz.load_stall_out = load_stall;
    assign hz.mc_busy        = rst && (state_reg == ST_MC_BUSY);
    assign hz.mc_done        = rst && mc_timer_done;
    assign hz.stall_cycles   = perf_val[0];
    assign hz.flush_events   = perf_val[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // {pc_en,if_id_en,id_ex_en,ex_mem_en, pc_sel, if_id_fl,id_ex_fl,ex_mem_fl, load_stall, mc_busy, mc_done}
    wire [10:0] ctl = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.pc_sel,
                       hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush,
                       hz.load_stall_out, hz.mc_busy, hz.mc_done};

    localparam logic [10:0] C_IDLE   = 11'b1111_0_000_0_0_0;
    localparam logic [10:0] C_RESET  = 11'b0000_0_111_0_0_0;
    localparam logic [10:0] C_LOAD   = 11'b0011_0_010_1_0_0;
    localparam logic [10:0] C_BRANCH = 11'b1111_1_110_0_0_0;
    localparam logic [10:0] C_MC_ST  = 11'b0001_0_001_0_0_0;
    localparam logic [10:0] C_MC_BSY = 11'b0001_0_001_0_1_0;
    localparam logic [10:0] C_MC_DN  = 11'b1111_0_000_0_1_1;
    localparam logic [10:0] C_MB_RUN = 11'b0000_0_000_0_0_0;
    localparam logic [10:0] C_MB_BSY = 11'b0000_0_000_0_1_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
        hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_mc_start = 1'b0;
        hz.ex_mc_is_div = 1'b0; hz.branch_taken_ex = 1'b0; hz.mem_busy = 1'b0;
        hz.perf_clr = 1'b0;
    endtask

    task automatic clear_perf();
        hz.perf_clr = 1'b1;
        tick();
        hz.perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        hz.ex_mc_start = 1'b1; hz.branch_taken_ex = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3; hz.id_use_rs1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== C_RESET) begin
                errors++;
                $display("FAIL reset_ctl[%0d]: got %b expected %b", i, ctl, C_RESET);
            end
            $display("reset cycle %0d ctl=%b", i, ctl);
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_IDLE);
        end
        checks++;
        if (hz.stall_cycles !== 32'd0 || hz.flush_events !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", hz.stall_cycles, hz.flush_events);
        end
        $display("reset released ctl=%b stall=%0d flush=%0d", ctl, hz.stall_cycles, hz.flush_events);
        tick();
    endtask

    task automatic test_load_use();
        clear_perf();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LOAD) begin
            errors++;
            $display("FAIL load_rs1_ctl: got %b expected %b", ctl, C_LOAD);
        end
        $display("load-use rs1 ctl=%b", ctl);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE || hz.stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL load_one_cycle: ctl %b stall %0d expected %b stall 1", ctl, hz.stall_cycles, C_IDLE);
        end
        // x0 destination never stalls
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL load_x0_ctl: got %b expected %b", ctl, C_IDLE);
        end
        $display("load-use x0 ctl=%b", ctl);
        tick();
        // matching rs1 that the instruction does not read
        hz.ex_rd = 5'd9; hz.id_rs1 = 5'd9; hz.id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL load_unused_ctl: got %b expected %b", ctl, C_IDLE);
        end
        tick();
        hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd9; hz.id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LOAD) begin
            errors++;
            $display("FAIL load_rs2_ctl: got %b expected %b", ctl, C_LOAD);
        end
        $display("load-use rs2 ctl=%b", ctl);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.stall_cycles !== 32'd2) begin
            errors++;
            $display("FAIL load_stall_count: got %0d expected 2", hz.stall_cycles);
        end
    endtask

    // Holds ex_mc_start for the whole op; mem_busy is raised on cycles mb_a and mb_b (>=1, -1 = none).
    task automatic run_mc(input logic is_div, input int lat, input int mb_a, input int mb_b, input string name);
        int nb;
        int total;
        logic [10:0] exp_ctl;
        nb = ((mb_a > 0) ? 1 : 0) + ((mb_b > 0) ? 1 : 0);
        total = lat + 1 + nb;
        clear_perf();
        hz.ex_mc_start = 1'b1; hz.ex_mc_is_div = is_div;
        for (int i = 0; i < total; i++) begin
            hz.mem_busy = (i == mb_a) || (i == mb_b);
            if (hz.mem_busy)       exp_ctl = C_MB_BSY;
            else if (i == 0)       exp_ctl = C_MC_ST;
            else if (i == total-1) exp_ctl = C_MC_DN;
            else                   exp_ctl = C_MC_BSY;
            #1;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL %s_cycle%0d: got %b expected %b", name, i, ctl, exp_ctl);
            end
            $display("%s cycle %0d ctl=%b", name, i, ctl);
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE || hz.stall_cycles !== 32'(lat + nb)) begin
            errors++;
            $display("FAIL %s_after: ctl %b stall %0d expected %b stall %0d", name, ctl, hz.stall_cycles, C_IDLE, lat + nb);
        end
    endtask

    task automatic test_branch_load();
        clear_perf();
        hz.branch_taken_ex = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs2 = 5'd7; hz.id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_load_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        $display("branch+load ctl=%b", ctl);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.flush_events !== 32'd1 || hz.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL branch_load_counters: got %0d/%0d expected 1/0", hz.flush_events, hz.stall_cycles);
        end
    endtask

    task automatic test_branch_mem_busy();
        clear_perf();
        hz.branch_taken_ex = 1'b1;
        hz.mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== C_MB_RUN) begin
                errors++;
                $display("FAIL branch_held[%0d]: got %b expected %b", i, ctl, C_MB_RUN);
            end
            $display("branch held cycle %0d ctl=%b", i, ctl);
            tick();
        end
        hz.mem_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_release: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.flush_events !== 32'd1 || hz.stall_cycles !== 32'd2) begin
            errors++;
            $display("FAIL branch_busy_counters: got %0d/%0d expected 1/2", hz.flush_events, hz.stall_cycles);
        end
    endtask

    task automatic test_reset_mid_div();
        clear_perf();
        hz.ex_mc_start = 1'b1; hz.ex_mc_is_div = 1'b1;
        // cycle 0 loads 15; after 8 more cycles the counter reads 7
        for (int i = 0; i < 9; i++) tick();
        checks++;
        #1;
        if (ctl !== C_MC_BSY) begin
            errors++;
            $display("FAIL mid_div_busy: got %b expected %b", ctl, C_MC_BSY);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RESET) begin
            errors++;
            $display("FAIL mid_div_reset: got %b expected %b", ctl, C_RESET);
        end
        tick();
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (ctl !== C_IDLE) begin
                errors++;
                $display("FAIL aborted_div[%0d]: got %b expected %b", i, ctl, C_IDLE);
            end
            tick();
        end
        $display("aborted div ctl=%b stall=%0d", ctl, hz.stall_cycles);
        checks++;
        if (hz.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL aborted_div_stall: got %0d expected 0", hz.stall_cycles);
        end
    endtask

    task automatic test_perf_clr();
        clear_perf();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd4; hz.id_rs1 = 5'd4; hz.id_use_rs1 = 1'b1;
        tick();
        #1;
        checks++;
        if (hz.stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL perf_pre: got %0d expected 1", hz.stall_cycles);
        end
        hz.perf_clr = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LOAD) begin
            errors++;
            $display("FAIL perf_clr_ctl: got %b expected %b", ctl, C_LOAD);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_clr_wins: got %0d expected 0", hz.stall_cycles);
        end
        $display("perf_clr with stall stall=%0d", hz.stall_cycles);
    endtask

    task automatic test_back_to_back();
        run_mc(1'b0, 3, -1, -1, "mul_b2b_a");
        run_mc(1'b0, 3, 2, -1, "mul_b2b_b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        run_mc(1'b0, 3, -1, -1, "mul");
        run_mc(1'b1, 16, -1, -1, "div");
        test_branch_load();
        run_mc(1'b1, 16, 3, 4, "div_membusy");
        test_branch_mem_busy();
        test_reset_mid_div();
        test_perf_clr();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
